// File: rtl/dw_bsr_chain.sv
// rtl/dw_bsr_chain.sv - WIDTH-cell boundary-scan register with capture/shift/update stages and sequencing FSM.
// Optional shift-length checker enabled by defining DW_BSR_SHIFT_CHK_EN.
module dw_bsr_chain #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] SAFE_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             mode,
    input  logic             intest,
    input  logic             si,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             so,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             busy,
    output logic             len_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_SHIFT = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_upd;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cnt_sat;

    assign w_cnt_sat = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap <= '0;
            r_cnt <= '0;
        end else if (capture_dr) begin
            r_cap <= intest ? r_upd : data_in;
            r_cnt <= '0;
        end else if (shift_dr) begin
            r_cap <= {si, r_cap[WIDTH-1:1]};
            if (!w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Nonblocking read of r_cap keeps a same-cycle shift/capture out of the update stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd <= SAFE_VAL;
        end else if (update_dr) begin
            r_upd <= r_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (capture_dr) begin
            w_state_nxt = S_CAPT;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_CAPT: begin
                    if (update_dr) begin
                        w_state_nxt = S_IDLE;
                    end else if (shift_dr) begin
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (update_dr) begin
                        w_state_nxt = S_IDLE;
                    end else if (!shift_dr) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (update_dr) begin
                        w_state_nxt = S_IDLE;
                    end else if (shift_dr) begin
                        w_state_nxt = S_SHIFT;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef DW_BSR_SHIFT_CHK_EN
    logic r_len_err;

    // Flags an update after a partial/over-length shift, or a shift past counter saturation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
        end else if (capture_dr) begin
            r_len_err <= 1'b0;
        end else if ((update_dr && (r_cnt != '0) && (r_cnt != CNT_W'(WIDTH)))
                     || (shift_dr && w_cnt_sat)) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`else
    assign len_err = 1'b0;
`endif

    assign data_out  = mode ? r_upd : data_in;
    assign so        = r_cap[0];
    assign shift_cnt = r_cnt;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dw_bsr_chain.sv
// tb/tb_dw_bsr_chain.sv - directed self-checking bench for dw_bsr_chain (WIDTH=8, SAFE_VAL=8'hA5).
module tb_dw_bsr_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       mode;
    logic       intest;
    logic       si;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       so;
    logic [3:0] shift_cnt;
    logic       busy;
    logic       len_err;

    int total = 0;
    int bad   = 0;

`ifdef DW_BSR_SHIFT_CHK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    dw_bsr_chain #(.WIDTH(8), .SAFE_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .intest(intest), .si(si),
        .data_in(data_in), .data_out(data_out), .so(so), .shift_cnt(shift_cnt),
        .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic c, input logic s, input logic u, input logic sin);
        capture_dr = c;
        shift_dr   = s;
        update_dr  = u;
        si         = sin;
        @(posedge clk);
        #1;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mode  = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL reset_data_out got=%h exp=a5", data_out); end
        total++; if (so !== 1'b0) begin bad++; $display("FAIL reset_so got=%b exp=0", so); end
        total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
    endtask

    task automatic test_mode_bypass;
        mode    = 1'b0;
        data_in = 8'h69;
        #1;
        total++; if (data_out !== 8'h69) begin bad++; $display("FAIL bypass got=%h exp=69", data_out); end
        mode = 1'b1;
        #1;
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL mode1_safe got=%h exp=a5", data_out); end
    endtask

    task automatic test_extest;
        logic [7:0] pat;
        pat = 8'h3C;
        data_in = 8'h00;
        intest  = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL extest_busy_capt got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, pat[i]);
        total++; if (shift_cnt !== 4'd8) begin bad++; $display("FAIL extest_cnt got=%0d exp=8", shift_cnt); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL extest_pre_update got=%h exp=a5", data_out); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL extest_data_out got=%h exp=3c", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL extest_busy_idle got=%b exp=0", busy); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL extest_len_err got=%b exp=0", len_err); end
    endtask

    task automatic test_sample;
        logic [7:0] exp_bits;
        logic       fb;
        exp_bits = 8'b1001_0110;
        data_in  = 8'h96;
        intest   = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (so !== exp_bits[i]) begin bad++; $display("FAIL sample_so[%0d] got=%b exp=%b", i, so, exp_bits[i]); end
            fb = so;
            tick(1'b0, 1'b1, 1'b0, fb);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'h96) begin bad++; $display("FAIL sample_wrap got=%h exp=96", data_out); end
    endtask

    task automatic test_intest;
        logic [7:0] pat;
        pat = 8'h5A;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b0, pat[i]);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL intest_preload got=%h exp=5a", data_out); end
        intest  = 1'b1;
        data_in = 8'hFF;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        intest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (so !== pat[i]) begin bad++; $display("FAIL intest_so[%0d] got=%b exp=%b", i, so, pat[i]); end
            tick(1'b0, 1'b1, 1'b0, 1'b0);
        end
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL intest_held got=%h exp=5a", data_out); end
    endtask

    task automatic test_collision;
        intest  = 1'b0;
        data_in = 8'hF0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        data_in = 8'h0F;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'hF0) begin bad++; $display("FAIL coll_upd got=%h exp=f0", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL coll_busy got=%b exp=1", busy); end
        total++; if (so !== 1'b1) begin bad++; $display("FAIL coll_so got=%b exp=1", so); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL coll_cap got=%h exp=0f", data_out); end
    endtask

    task automatic test_fsm_pause;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pause_busy got=%b exp=1", busy); end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (shift_cnt !== 4'd2) begin bad++; $display("FAIL pause_cnt got=%0d exp=2", shift_cnt); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_idle got=%b exp=0", busy); end
    endtask

    task automatic test_checker;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (len_err !== CHK_ON) begin bad++; $display("FAIL chk_short got=%b exp=%b", len_err, CHK_ON); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL chk_clear got=%b exp=0", len_err); end
    endtask

    task automatic test_saturation;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (shift_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", shift_cnt); end
        total++; if (len_err !== CHK_ON) begin bad++; $display("FAIL sat_len_err got=%b exp=%b", len_err, CHK_ON); end
    endtask

    task automatic test_reset_mid_shift;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        total++; if (shift_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", shift_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL rstmid_upd got=%h exp=a5", data_out); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_cap got=%h exp=00", data_out); end
    endtask

    initial begin
        rst_n      = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        mode       = 1'b1;
        intest     = 1'b0;
        si         = 1'b0;
        data_in    = 8'h00;
        #1;
        test_reset;
        test_mode_bypass;
        test_extest;
        test_sample;
        test_intest;
        test_collision;
        test_fsm_pause;
        test_checker;
        test_saturation;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
